// File: rtl/batch_variance.sv
// batch_variance: buffers a batch of N signed Q(IL.FL) samples, computes the
// batch mean (floor of sum/N), then makes a second pass over the buffer to
// form the biased variance plus EPS, saturated to the positive W-bit range.
// Results are held with done=1 until the consumer pulses output_taken.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous, active-low reset
//   in           in   W-bit signed sample
//   in_valid     in   in carries a sample this cycle
//   in_ready     out  block accepts a sample this cycle (state==LOAD)
//   output_taken in   consumer has taken mean/var_eps
//   mean         out  W-bit signed batch mean
//   var_eps      out  W-bit signed variance + EPS, never negative
//   state        out  current FSM state (00 LOAD, 01 MEAN, 10 VAR, 11 DONE)
//   done         out  mean/var_eps valid
module batch_variance #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int N     = 16,
  parameter int LOG2N = 4,
  parameter int EPS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IL+FL-1:0]    in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       output_taken,
  output logic signed [IL+FL-1:0]    mean,
  output logic signed [IL+FL-1:0]    var_eps,
  output logic        [1:0]          state,
  output logic                       done
);

  localparam int W      = IL + FL;
  localparam int SUM_W  = W + LOG2N;
  localparam int DIFF_W = W + 1;
  localparam int PROD_W = 2 * DIFF_W;
  // Each squared term is below 2^(2W-FL); N of them need LOG2N more bits,
  // plus one bit of headroom.
  localparam int ACC_W  = 2 * W - FL + LOG2N + 1;
  localparam int CNT_W  = LOG2N + 1;
  localparam int VMAX   = 2 ** (W - 1) - 1;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_MEAN = 2'b01,
    S_VAR  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [ACC_W-1:0]         sq_acc_q, sq_acc_d;
  logic signed [W-1:0]      mean_r_q, mean_r_d;
  logic signed [W-1:0]      mean_q, mean_d;
  logic signed [W-1:0]      var_eps_q, var_eps_d;
  logic                     done_q, done_d;
  logic                     wr_en;

  logic signed [W-1:0]      buf_q [N];

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         sq;

  // Mean of squares plus EPS, clamped to the largest positive W-bit value.
  function automatic logic signed [W-1:0] sat_var(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] v;
    v = (acc >> LOG2N) + ACC_W'(EPS);
    if (v > ACC_W'(VMAX)) return W'(VMAX);
    return W'(v);
  endfunction

  // Second-pass datapath: the index wraps to entry 0 on the finalize cycle,
  // where the product is not used.
  assign diff = DIFF_W'(buf_q[count_q[LOG2N-1:0]]) - DIFF_W'(mean_r_q);
  assign prod = diff * diff;
  assign sq   = ACC_W'($unsigned(prod >> FL));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    sq_acc_d  = sq_acc_q;
    mean_r_d  = mean_r_q;
    mean_d    = mean_q;
    var_eps_d = var_eps_q;
    done_d    = done_q;
    wr_en     = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + SUM_W'(in);
          if (count_q == CNT_W'(N - 1)) begin
            count_d = '0;
            state_d = S_MEAN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_MEAN: begin
        // Arithmetic shift gives floor(sum/N), which always fits W bits.
        mean_r_d = W'(sum_q >>> LOG2N);
        sq_acc_d = '0;
        count_d  = '0;
        state_d  = S_VAR;
      end
      S_VAR: begin
        // Entries 0..N-1 accumulate; the extra count value N is the finalize edge.
        if (count_q == CNT_W'(N)) begin
          var_eps_d = sat_var(sq_acc_q);
          mean_d    = mean_r_q;
          done_d    = 1'b1;
          count_d   = '0;
          state_d   = S_DONE;
        end else begin
          sq_acc_d = sq_acc_q + sq;
          count_d  = count_q + 1'b1;
        end
      end
      S_DONE: begin
        if (output_taken) begin
          done_d  = 1'b0;
          sum_d   = '0;
          count_d = '0;
          state_d = S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      count_q   <= '0;
      sum_q     <= '0;
      sq_acc_q  <= '0;
      mean_q    <= '0;
      var_eps_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      sq_acc_q  <= sq_acc_d;
      mean_q    <= mean_d;
      var_eps_q <= var_eps_d;
      done_q    <= done_d;
    end
  end

  // Sample buffer and working mean are pure data and need no reset.
  always_ff @(posedge clk) begin
    mean_r_q <= mean_r_d;
    if (wr_en) buf_q[count_q[LOG2N-1:0]] <= in;
  end

  assign in_ready = (state_q == S_LOAD);
  assign state    = state_q;
  assign mean     = mean_q;
  assign var_eps  = var_eps_q;
  assign done     = done_q;

endmodule

// File: doc/batch_variance.md
Name: batch_variance

Overview:
- Upstream stage of the batch-normalization square-root unit.
- Buffers a batch of N signed fixed-point activations and computes the batch mean in a first pass.
- Computes the biased variance plus epsilon in a second pass over the buffer.
- Presents mean and var_eps with the same done/output_taken handshake the sqrt stage uses; var_eps drives the sqrt stage's in, and mean goes forward to the normalization stage.

Parameters:
- IL, 4: integer bits, sign included.
- FL, 16: fraction bits. W = IL+FL.
- N, 16: batch size; must be a power of two, at least 2.
- LOG2N, 4: log2(N).
- EPS, 1: epsilon in LSBs, added to the variance.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- in  in  W  signed Q(IL.FL) sample.
- in_valid  in  1  in carries a sample this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- output_taken  in  1  consumer has taken mean/var_eps.
- mean  out  W  signed batch mean.
- var_eps  out  W  signed variance + EPS, always >= 0.
- state  out  2  current FSM state.
- done  out  1  mean/var_eps valid.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low (sampled at posedge clk while reset==0).
  - Reset takes effect in any state, including mid-batch: the partial batch is discarded.
  - Reset values: state=LOAD, count=0, sum=0, sq_acc=0, mean=0, var_eps=0, done=0.
- FSM encoding: 00 LOAD, 01 MEAN, 10 VAR, 11 DONE.
- in_ready = (state==LOAD), combinational.
- LOAD:
  - Each edge with in_valid && in_ready writes in into buf[count], adds it to sum and increments count.
  - sum is a signed register of W+LOG2N bits, so it never overflows.
  - On the edge accepting sample N-1: count returns to 0 and state goes to MEAN.
  - in_valid with in_ready==0 is ignored; nothing is dropped into the buffer.
- MEAN (exactly 1 cycle):
  - mean_r = sum >>> LOG2N, an arithmetic shift (floor); it always fits W bits.
  - sq_acc is cleared and state goes to VAR.
- VAR (exactly N cycles, one buffer entry per cycle, index 0..N-1):
  - diff = buf[i] - mean_r, W+1 bits signed.
  - sq = (diff*diff) >> FL, non-negative and truncated.
  - sq_acc += sq; sq_acc is wide enough for N*2^(2W-FL) with no overflow.
  - After entry N-1, the next edge (finalize):
    - var = (sq_acc >> LOG2N) + EPS;
    - var_eps = min(var, 2^(W-1)-1), saturating;
    - mean output = mean_r; done = 1; state = DONE.
- Latency: if edge k accepts the last sample, done is high after edge k+N+2.
- DONE:
  - mean, var_eps and done are held indefinitely.
  - output_taken==1 at an edge: done=0, state=LOAD, sum=0, count=0.
  - mean and var_eps keep their last values until the next finalize.
- output_taken outside DONE is ignored.
- in_valid during MEAN/VAR/DONE is ignored; the producer must hold it.
- First sample of the next batch is accepted no earlier than the edge after output_taken.

Test Plan:
- Reset; 16 samples of 1020 back-to-back -> mean=1020, var_eps=1, done rises after edge k+18, state=11.
- 8 samples 0 then 8 samples 65536 (1.0) -> mean=32768, var_eps=16385.
- Alternating 524287/-524288 x8 -> mean=-1 (floor), var_eps saturates to 524287.
- Hold in_valid=1 through DONE for 20 cycles, then output_taken pulse -> in_ready=0 until the edge after the pulse; no extra sample counted; second batch of 1020s gives mean=1020, var_eps=1.
- Gapped in_valid (every third cycle), 16 samples of -65536 -> mean=-65536, var_eps=1; count advances only on valid cycles.
- Reset low during VAR (after 5 entries) -> next edge state=00, done=0, mean=0, var_eps=0; a fresh full batch then gives correct results.
